exec_stage_pipe: RTL and testbench

Parametrised execution stage of the pipelined core; successor to the fixed 24-bit execute stage. It sits between decode/register-read and the memory stage and computes the ALU result, the next PC and the NZCV flags. Control and writeback fields are carried through a pipeline register. New relative to the previous generation: configurable data width, an iterative multi-cycle multiplier, a valid/stall/flush handshake, and a registered flags output.

---
 rtl/exec_pkg.sv | 26 ++
 rtl/alu_comb.sv | 60 ++++++
 rtl/exec_stage_pipe.sv | 223 ++++++++++++++++++++++
 tb/tb_exec_stage_pipe.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage: ALU mode encoding,
// NZCV bit positions and the multiply sequencer states.
package exec_pkg;

    typedef enum logic [2:0] {
        MODE_ADD = 3'b000,
        MODE_CMP = 3'b001,
        MODE_SUB = 3'b010,
        MODE_AND = 3'b011,
        MODE_OR  = 3'b100,
        MODE_XOR = 3'b101,
        MODE_SHL = 3'b110,
        MODE_MUL = 3'b111
    } alu_mode_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU: result and NZCV for every mode except MUL, which is
// produced by the iterative multiplier in the stage itself.
module alu_comb
    import exec_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    input  alu_mode_t         alu_mode,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags
);

    localparam int SHAMT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W:0]    sum;
    logic [DATA_W:0]    diff;
    logic [DATA_W-1:0]  res;
    logic [SHAMT_W-1:0] shamt;
    logic               carry;
    logic               ovf;

    assign sum   = {1'b0, op1} + {1'b0, op2};
    assign diff  = {1'b0, op1} - {1'b0, op2};
    assign shamt = op2[SHAMT_W-1:0];

    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (alu_mode)
            MODE_ADD: begin
                res   = sum[DATA_W-1:0];
                carry = sum[DATA_W];
                ovf   = (op1[DATA_W-1] == op2[DATA_W-1]) && (sum[DATA_W-1] != op1[DATA_W-1]);
            end
            // The top bit of the widened difference is the borrow, so C is its inverse.
            MODE_SUB, MODE_CMP: begin
                res   = diff[DATA_W-1:0];
                carry = ~diff[DATA_W];
                ovf   = (op1[DATA_W-1] != op2[DATA_W-1]) && (diff[DATA_W-1] != op1[DATA_W-1]);
            end
            MODE_AND: res = op1 & op2;
            MODE_OR:  res = op1 | op2;
            MODE_XOR: res = op1 ^ op2;
            MODE_SHL: res = op1 << shamt;
            default:  res = '0;
        endcase

        flags         = '0;
        flags[FLAG_N] = res[DATA_W-1];
        flags[FLAG_Z] = (res == '0);
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;

        result = (alu_mode == MODE_CMP) ? {{(DATA_W-4){1'b0}}, flags} : res;
    end

endmodule

// File: rtl/exec_stage_pipe.sv
// Execute stage: single-cycle ALU ops, a MUL_BITS-per-cycle shift-add
// multiplier, the output pipeline register and the architectural flags.
module exec_stage_pipe #(
    parameter int DATA_W     = 24,
    parameter int REG_ADDR_W = 4,
    parameter int MUL_BITS   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  mem_we,
    input  logic                  reg_we,
    input  logic                  write_reg_from_alu,
    input  logic                  pc_we,
    input  logic                  flags_we,
    input  logic [DATA_W-1:0]     data_to_write,
    input  logic [DATA_W-1:0]     op1,
    input  logic [DATA_W-1:0]     op2,
    input  logic [DATA_W-1:0]     pcm4,
    input  logic [REG_ADDR_W-1:0] reg_to_write,
    input  logic [2:0]            alu_mode,
    input  logic                  stall_in,
    input  logic                  flush,
    output logic                  stall_out,
    output logic                  out_valid,
    output logic                  mem_we_out,
    output logic                  reg_we_out,
    output logic                  write_reg_from_alu_out,
    output logic                  pc_we_out,
    output logic [REG_ADDR_W-1:0] reg_to_write_out,
    output logic [DATA_W-1:0]     data_to_write_out,
    output logic [DATA_W-1:0]     result,
    output logic [DATA_W-1:0]     new_pc,
    output logic [3:0]            flags
);
    import exec_pkg::*;

    localparam int MUL_STEPS = DATA_W / MUL_BITS;
    localparam int CNT_W     = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;

    state_t            stateReg, stateNext;
    logic [CNT_W-1:0]  countReg;
    logic [DATA_W-1:0] mcandReg, mplierReg, accReg, accNext, partSum;
    logic [DATA_W-1:0] partProd [MUL_BITS];

    logic                  mulMemWe, mulRegWe, mulWrFromAlu, mulPcWe, mulFlagsWe;
    logic [REG_ADDR_W-1:0] mulRegToWrite;
    logic [DATA_W-1:0]     mulDataToWrite, mulPcm4;
    logic [3:0]            mulFlags;

    alu_mode_t         mode;
    logic [DATA_W-1:0] aluResult;
    logic [3:0]        aluFlags;
    logic              isMul, idleLoad, mulStart, busyDone, loadOut;

    logic                  selMemWe, selRegWe, selWrFromAlu, selPcWe, selFlagsWe;
    logic [REG_ADDR_W-1:0] selRegToWrite;
    logic [DATA_W-1:0]     selData, selResult, selNewPc;
    logic [3:0]            selFlags;

    assign mode = alu_mode_t'(alu_mode);

    alu_comb #(.DATA_W(DATA_W)) u_alu (
        .op1      (op1),
        .op2      (op2),
        .alu_mode (mode),
        .result   (aluResult),
        .flags    (aluFlags)
    );

    assign isMul    = (mode == MODE_MUL);
    assign idleLoad = (stateReg == IDLE) && in_valid && !isMul;
    assign mulStart = (stateReg == IDLE) && in_valid && isMul;
    assign busyDone = (stateReg == BUSY) && (countReg == '0);
    assign loadOut  = idleLoad || busyDone;

    assign stall_out = !reset && ((stateReg == BUSY) || stall_in);

    // One partial product per multiplier bit retired this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < MUL_BITS; gi++) begin : g_pp
            assign partProd[gi] = mplierReg[gi] ? (mcandReg << gi) : '0;
        end
    endgenerate

    always_comb begin
        partSum = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            partSum = partSum + partProd[i];
        end
    end

    assign accNext = accReg + partSum;

    always_comb begin
        mulFlags         = '0;
        mulFlags[FLAG_N] = accNext[DATA_W-1];
        mulFlags[FLAG_Z] = (accNext == '0);
    end

    // Output bundle comes from the live inputs in IDLE, from the latched MUL bundle in BUSY.
    always_comb begin
        selResult     = aluResult;
        selFlags      = aluFlags;
        selMemWe      = mem_we;
        selRegWe      = reg_we;
        selWrFromAlu  = write_reg_from_alu;
        selPcWe       = pc_we;
        selFlagsWe    = flags_we;
        selRegToWrite = reg_to_write;
        selData       = data_to_write;
        selNewPc      = pc_we ? aluResult : pcm4;
        if (stateReg == BUSY) begin
            selResult     = accNext;
            selFlags      = mulFlags;
            selMemWe      = mulMemWe;
            selRegWe      = mulRegWe;
            selWrFromAlu  = mulWrFromAlu;
            selPcWe       = mulPcWe;
            selFlagsWe    = mulFlagsWe;
            selRegToWrite = mulRegToWrite;
            selData       = mulDataToWrite;
            selNewPc      = mulPcWe ? accNext : mulPcm4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        if (flush) begin
            stateNext = IDLE;
        end else if (!stall_in) begin
            case (stateReg)
                IDLE:    if (mulStart) stateNext = BUSY;
                BUSY:    if (busyDone) stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            countReg       <= '0;
            mcandReg       <= '0;
            mplierReg      <= '0;
            accReg         <= '0;
            mulMemWe       <= 1'b0;
            mulRegWe       <= 1'b0;
            mulWrFromAlu   <= 1'b0;
            mulPcWe        <= 1'b0;
            mulFlagsWe     <= 1'b0;
            mulRegToWrite  <= '0;
            mulDataToWrite <= '0;
            mulPcm4        <= '0;
        end else if (!flush && !stall_in) begin
            if (mulStart) begin
                countReg       <= CNT_W'(MUL_STEPS - 1);
                mcandReg       <= op1;
                mplierReg      <= op2;
                accReg         <= '0;
                mulMemWe       <= mem_we;
                mulRegWe       <= reg_we;
                mulWrFromAlu   <= write_reg_from_alu;
                mulPcWe        <= pc_we;
                mulFlagsWe     <= flags_we;
                mulRegToWrite  <= reg_to_write;
                mulDataToWrite <= data_to_write;
                mulPcm4        <= pcm4;
            end else if (stateReg == BUSY) begin
                countReg  <= countReg - 1'b1;
                mcandReg  <= mcandReg << MUL_BITS;
                mplierReg <= mplierReg >> MUL_BITS;
                accReg    <= accNext;
            end
        end
    end

    // Write enables are gated with loadOut so a bubble never carries a stale enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid              <= 1'b0;
            mem_we_out             <= 1'b0;
            reg_we_out             <= 1'b0;
            write_reg_from_alu_out <= 1'b0;
            pc_we_out              <= 1'b0;
            reg_to_write_out       <= '0;
            data_to_write_out      <= '0;
            result                 <= '0;
            new_pc                 <= '0;
            flags                  <= '0;
        end else if (flush) begin
            out_valid              <= 1'b0;
            mem_we_out             <= 1'b0;
            reg_we_out             <= 1'b0;
            write_reg_from_alu_out <= 1'b0;
            pc_we_out              <= 1'b0;
        end else if (!stall_in) begin
            out_valid              <= loadOut;
            mem_we_out             <= loadOut && selMemWe;
            reg_we_out             <= loadOut && selRegWe;
            write_reg_from_alu_out <= loadOut && selWrFromAlu;
            pc_we_out              <= loadOut && selPcWe;
            if (loadOut) begin
                reg_to_write_out  <= selRegToWrite;
                data_to_write_out <= selData;
                result            <= selResult;
                new_pc            <= selNewPc;
                if (selFlagsWe) begin
                    flags <= selFlags;
                end
            end
        end
    end

endmodule

// File: tb/tb_exec_stage_pipe.sv
// Self-checking bench for exec_stage_pipe: directed scenarios plus randomized
// instructions checked against an arithmetic reference model.
module tb_exec_stage_pipe;

    localparam int DW      = 24;
    localparam int RW      = 4;
    localparam int MUL_LAT = DW / 4;
    localparam longint MOD  = 64'd1 << DW;
    localparam longint HALF = 64'd1 << (DW - 1);

    localparam logic [2:0] M_ADD = 3'd0;
    localparam logic [2:0] M_CMP = 3'd1;
    localparam logic [2:0] M_SUB = 3'd2;
    localparam logic [2:0] M_MUL = 3'd7;

    logic          clk, reset;
    logic          in_valid, mem_we, reg_we, write_reg_from_alu, pc_we, flags_we;
    logic [DW-1:0] data_to_write, op1, op2, pcm4;
    logic [RW-1:0] reg_to_write;
    logic [2:0]    alu_mode;
    logic          stall_in, flush;
    logic          stall_out, out_valid, mem_we_out, reg_we_out, write_reg_from_alu_out, pc_we_out;
    logic [RW-1:0] reg_to_write_out;
    logic [DW-1:0] data_to_write_out, result, new_pc;
    logic [3:0]    flags;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] expFlags = '0;

    exec_stage_pipe dut (
        .clk                    (clk),
        .reset                  (reset),
        .in_valid               (in_valid),
        .mem_we                 (mem_we),
        .reg_we                 (reg_we),
        .write_reg_from_alu     (write_reg_from_alu),
        .pc_we                  (pc_we),
        .flags_we               (flags_we),
        .data_to_write          (data_to_write),
        .op1                    (op1),
        .op2                    (op2),
        .pcm4                   (pcm4),
        .reg_to_write           (reg_to_write),
        .alu_mode               (alu_mode),
        .stall_in               (stall_in),
        .flush                  (flush),
        .stall_out              (stall_out),
        .out_valid              (out_valid),
        .mem_we_out             (mem_we_out),
        .reg_we_out             (reg_we_out),
        .write_reg_from_alu_out (write_reg_from_alu_out),
        .pc_we_out              (pc_we_out),
        .reg_to_write_out       (reg_to_write_out),
        .data_to_write_out      (data_to_write_out),
        .result                 (result),
        .new_pc                 (new_pc),
        .flags                  (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void ref_alu(input logic [2:0] mode, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                    output logic [DW-1:0] res, output logic [3:0] nzcv);
        longint ua, ub, sa, sb, full, sres;
        logic [DW-1:0] r;
        logic c, v;
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= HALF) ? ua - MOD : ua;
        sb = (ub >= HALF) ? ub - MOD : ub;
        c = 1'b0;
        v = 1'b0;
        case (mode)
            3'd0: begin
                full = ua + ub;
                sres = sa + sb;
                r = DW'(full % MOD);
                c = (full >= MOD);
                v = (sres >= HALF) || (sres < -HALF);
            end
            3'd1, 3'd2: begin
                full = ua - ub + MOD;
                sres = sa - sb;
                r = DW'(full % MOD);
                c = (ua >= ub);
                v = (sres >= HALF) || (sres < -HALF);
            end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = DW'((ua << (ub % 32)) % MOD);
            default: r = DW'((ua * ub) % MOD);
        endcase
        nzcv = {r[DW-1], (r == '0), c, v};
        res = (mode == 3'd1) ? DW'(nzcv) : r;
    endfunction

    function automatic logic [DW-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return DW'(1);
            2: return {DW{1'b1}};
            3: return {1'b1, {(DW-1){1'b0}}};
            4: return {1'b0, {(DW-1){1'b1}}};
            default: return DW'($urandom);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; mem_we = 0; reg_we = 0; write_reg_from_alu = 0; pc_we = 0; flags_we = 0;
        data_to_write = '0; op1 = '0; op2 = '0; pcm4 = '0; reg_to_write = '0; alu_mode = '0;
        stall_in = 0; flush = 0;
    endtask

    task automatic drive(input logic [2:0] mode, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] pc, input logic pcwe, input logic fwe, input logic mwe,
                         input logic rwe, input logic wfa, input logic [RW-1:0] rd, input logic [DW-1:0] dat);
        in_valid = 1; alu_mode = mode; op1 = a; op2 = b; pcm4 = pc; pc_we = pcwe; flags_we = fwe;
        mem_we = mwe; reg_we = rwe; write_reg_from_alu = wfa; reg_to_write = rd; data_to_write = dat;
    endtask

    // Presents one instruction, then waits (bounded) for out_valid.
    task automatic run_instr(input logic [2:0] mode, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [DW-1:0] pc, input logic pcwe, input logic fwe, input logic mwe,
                             input logic rwe, input logic wfa, input logic [RW-1:0] rd, input logic [DW-1:0] dat,
                             output int cyc, output bit stallOk);
        drive(mode, a, b, pc, pcwe, fwe, mwe, rwe, wfa, rd, dat);
        step();
        in_valid = 0;
        cyc = 0;
        stallOk = 1;
        while (out_valid !== 1'b1 && cyc < 20) begin
            if (stall_out !== 1'b1) stallOk = 0;
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        step();
        step();
        checks++;
        if ({out_valid, mem_we_out, reg_we_out, write_reg_from_alu_out, pc_we_out, reg_to_write_out,
             data_to_write_out, result, new_pc, flags} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b result=%h new_pc=%h flags=%b, want all zero",
                     out_valid, result, new_pc, flags);
        end
        stall_in = 1;
        #1;
        checks++;
        if (stall_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall_out: got %b, want 0", stall_out);
        end
        stall_in = 0;
        @(negedge clk);
        reset = 0;
        step();
        $display("reset: released");
    endtask

    task automatic test_add();
        int cyc; bit sok;
        run_instr(M_ADD, 24'd1, 24'd2, 24'd7, 0, 0, 0, 0, 0, 4'd0, 24'd0, cyc, sok);
        $display("add: 1+2 -> result=%h new_pc=%h", result, new_pc);
        checks++;
        if (cyc !== 0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL add_latency: got %0d extra cycles valid=%b, want 0 and 1", cyc, out_valid);
        end
        checks++;
        if (result !== 24'd3 || new_pc !== 24'd7) begin
            errors++;
            $display("FAIL add_result: got result=%h new_pc=%h, want 000003/000007", result, new_pc);
        end
        checks++;
        if (flags !== expFlags) begin
            errors++;
            $display("FAIL add_flags_hold: got %b, want %b", flags, expFlags);
        end
        step();
        checks++;
        if (out_valid !== 1'b0 || {mem_we_out, reg_we_out, write_reg_from_alu_out, pc_we_out} !== 4'b0) begin
            errors++;
            $display("FAIL add_bubble: got valid=%b we=%b%b%b%b, want all 0", out_valid,
                     mem_we_out, reg_we_out, write_reg_from_alu_out, pc_we_out);
        end
    endtask

    task automatic test_redirect();
        int cyc; bit sok;
        run_instr(M_ADD, 24'd2, 24'd3, 24'd3, 1, 0, 0, 0, 0, 4'd0, 24'd0, cyc, sok);
        $display("redirect: 2+3 -> result=%h new_pc=%h pc_we_out=%b", result, new_pc, pc_we_out);
        checks++;
        if (result !== 24'd5 || new_pc !== 24'd5 || pc_we_out !== 1'b1) begin
            errors++;
            $display("FAIL redirect: got result=%h new_pc=%h pc_we_out=%b, want 000005/000005/1",
                     result, new_pc, pc_we_out);
        end
    endtask

    task automatic test_cmp();
        int cyc; bit sok;
        run_instr(M_CMP, 24'd3, 24'd5, 24'd0, 0, 1, 0, 0, 0, 4'd0, 24'd0, cyc, sok);
        expFlags = 4'b1000;
        $display("cmp: 3 vs 5 -> result=%h flags=%b", result, flags);
        checks++;
        if (result !== 24'h000008 || flags !== 4'b1000) begin
            errors++;
            $display("FAIL cmp_lt: got result=%h flags=%b, want 000008/1000", result, flags);
        end
        run_instr(M_CMP, 24'd5, 24'd5, 24'd0, 0, 1, 0, 0, 0, 4'd0, 24'd0, cyc, sok);
        expFlags = 4'b0110;
        $display("cmp: 5 vs 5 -> result=%h flags=%b", result, flags);
        checks++;
        if (result !== 24'h000006 || flags !== 4'b0110) begin
            errors++;
            $display("FAIL cmp_eq: got result=%h flags=%b, want 000006/0110", result, flags);
        end
    endtask

    task automatic test_mul();
        int cyc; bit sok;
        run_instr(M_MUL, 24'h000123, 24'h000010, 24'h000040, 0, 0, 0, 1, 1, 4'd3, 24'd0, cyc, sok);
        $display("mul: 123*10 -> result=%h after %0d busy cycles", result, cyc);
        checks++;
        if (cyc !== MUL_LAT || !sok) begin
            errors++;
            $display("FAIL mul_latency: got %0d busy cycles stall_ok=%b, want %0d and 1", cyc, sok, MUL_LAT);
        end
        checks++;
        if (result !== 24'h001230 || new_pc !== 24'h000040 || reg_we_out !== 1'b1 || reg_to_write_out !== 4'd3) begin
            errors++;
            $display("FAIL mul_result: got result=%h new_pc=%h reg_we=%b rd=%0d, want 001230/000040/1/3",
                     result, new_pc, reg_we_out, reg_to_write_out);
        end
        run_instr(M_MUL, 24'h800000, 24'd2, 24'd0, 0, 1, 0, 0, 0, 4'd0, 24'd0, cyc, sok);
        expFlags = 4'b0100;
        $display("mul: 800000*2 -> result=%h flags=%b", result, flags);
        checks++;
        if (result !== 24'h000000 || flags !== 4'b0100 || cyc !== MUL_LAT) begin
            errors++;
            $display("FAIL mul_overflow: got result=%h flags=%b cycles=%0d, want 000000/0100/%0d",
                     result, flags, cyc, MUL_LAT);
        end
    endtask

    task automatic test_stall_passthrough();
        int cyc; bit sok;
        run_instr(M_ADD, 24'd10, 24'd20, 24'd0, 0, 0, 0, 0, 0, 4'd9, 24'h000055, cyc, sok);
        drive(M_ADD, 24'd4, 24'd5, 24'd0, 0, 0, 1, 1, 1, 4'd1, 24'd1);
        stall_in = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            $display("stall: cycle %0d valid=%b rd=%0d data=%h", i, out_valid, reg_to_write_out, data_to_write_out);
            checks++;
            if (out_valid !== 1'b1 || result !== 24'd30 || reg_to_write_out !== 4'd9 ||
                data_to_write_out !== 24'h000055 || mem_we_out !== 1'b0 || stall_out !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold: got valid=%b result=%h rd=%0d data=%h mem_we=%b stall_out=%b, want 1/00001e/9/000055/0/1",
                         out_valid, result, reg_to_write_out, data_to_write_out, mem_we_out, stall_out);
            end
        end
        stall_in = 0;
        step();
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || mem_we_out !== 1'b1 || reg_we_out !== 1'b1 || write_reg_from_alu_out !== 1'b1 ||
            reg_to_write_out !== 4'd1 || data_to_write_out !== 24'd1 || result !== 24'd9) begin
            errors++;
            $display("FAIL stall_release: got valid=%b we=%b%b%b rd=%0d data=%h result=%h, want 1/111/1/000001/000009",
                     out_valid, mem_we_out, reg_we_out, write_reg_from_alu_out, reg_to_write_out,
                     data_to_write_out, result);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_flush();
        int cyc; bit sok; bit sawValid;
        drive(M_MUL, 24'h000321, 24'h000007, 24'd0, 1, 1, 1, 1, 1, 4'd5, 24'd0);
        step();
        in_valid = 0;
        step();
        step();
        flush = 1;
        step();
        flush = 0;
        $display("flush: mid-mul valid=%b stall_out=%b flags=%b", out_valid, stall_out, flags);
        checks++;
        if (out_valid !== 1'b0 || {mem_we_out, reg_we_out, write_reg_from_alu_out, pc_we_out} !== 4'b0 ||
            stall_out !== 1'b0 || flags !== expFlags) begin
            errors++;
            $display("FAIL flush_mul: got valid=%b we=%b%b%b%b stall_out=%b flags=%b, want 0/0000/0/%b",
                     out_valid, mem_we_out, reg_we_out, write_reg_from_alu_out, pc_we_out, stall_out, flags, expFlags);
        end
        sawValid = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid === 1'b1) sawValid = 1;
        end
        checks++;
        if (sawValid) begin
            errors++;
            $display("FAIL flush_abort: got a late out_valid after flush, want none");
        end
        run_instr(M_ADD, 24'd1, 24'd1, 24'd0, 0, 0, 1, 1, 0, 4'd2, 24'd0, cyc, sok);
        stall_in = 1;
        flush = 1;
        drive(M_ADD, 24'd6, 24'd6, 24'd0, 0, 1, 1, 1, 1, 4'd2, 24'd0);
        step();
        clear_inputs();
        $display("flush: over stall valid=%b mem_we_out=%b", out_valid, mem_we_out);
        checks++;
        if (out_valid !== 1'b0 || mem_we_out !== 1'b0 || reg_we_out !== 1'b0 || flags !== expFlags) begin
            errors++;
            $display("FAIL flush_over_stall: got valid=%b mem_we=%b reg_we=%b flags=%b, want 0/0/0/%b",
                     out_valid, mem_we_out, reg_we_out, flags, expFlags);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_accept: got valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_busy();
        int cyc; bit sok;
        run_instr(M_CMP, 24'd3, 24'd5, 24'd0, 0, 1, 0, 0, 0, 4'd0, 24'd0, cyc, sok);
        expFlags = 4'b1000;
        drive(M_MUL, 24'h00abcd, 24'h000033, 24'h000100, 0, 1, 1, 1, 1, 4'd7, 24'h000077);
        step();
        in_valid = 0;
        step();
        #1;
        reset = 1;
        #1;
        expFlags = '0;
        $display("reset_mid_busy: result=%h flags=%b stall_out=%b", result, flags, stall_out);
        checks++;
        if (result !== '0 || flags !== 4'b0 || new_pc !== '0 || out_valid !== 1'b0 || stall_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got result=%h flags=%b new_pc=%h valid=%b stall_out=%b, want all 0",
                     result, flags, new_pc, out_valid, stall_out);
        end
        #1;
        reset = 0;
        step();
        checks++;
        if (out_valid !== 1'b0 || stall_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: got valid=%b stall_out=%b, want 0/0", out_valid, stall_out);
        end
    endtask

    task automatic test_random();
        int cyc; bit sok;
        logic [2:0] mode; logic [DW-1:0] a, b, pc, dat, expRes; logic [3:0] nz;
        logic pcwe, fwe, mwe, rwe, wfa; logic [RW-1:0] rd;
        for (int n = 0; n < 40; n++) begin
            mode = 3'($urandom_range(0, 7));
            a = pick_operand(); b = pick_operand();
            pc = DW'($urandom); dat = DW'($urandom); rd = RW'($urandom);
            pcwe = 1'($urandom_range(0, 1)); fwe = 1'($urandom_range(0, 1));
            mwe = 1'($urandom_range(0, 1)); rwe = 1'($urandom_range(0, 1)); wfa = 1'($urandom_range(0, 1));
            ref_alu(mode, a, b, expRes, nz);
            if (fwe) expFlags = nz;
            run_instr(mode, a, b, pc, pcwe, fwe, mwe, rwe, wfa, rd, dat, cyc, sok);
            $display("txn %0d: mode=%0d a=%h b=%h -> result=%h flags=%b cycles=%0d", n, mode, a, b, result, flags, cyc);
            checks++;
            if (cyc !== ((mode == M_MUL) ? MUL_LAT : 0) || !sok) begin
                errors++;
                $display("FAIL rand_latency: txn %0d got %0d cycles stall_ok=%b, want %0d", n, cyc, sok,
                         (mode == M_MUL) ? MUL_LAT : 0);
            end
            checks++;
            if (result !== expRes || new_pc !== (pcwe ? expRes : pc) || flags !== expFlags) begin
                errors++;
                $display("FAIL rand_result: txn %0d got result=%h new_pc=%h flags=%b, want %h/%h/%b", n,
                         result, new_pc, flags, expRes, pcwe ? expRes : pc, expFlags);
            end
            checks++;
            if ({mem_we_out, reg_we_out, write_reg_from_alu_out, pc_we_out, reg_to_write_out, data_to_write_out} !==
                {mwe, rwe, wfa, pcwe, rd, dat}) begin
                errors++;
                $display("FAIL rand_passthru: txn %0d got we=%b%b%b%b rd=%0d data=%h, want %b%b%b%b/%0d/%h", n,
                         mem_we_out, reg_we_out, write_reg_from_alu_out, pc_we_out, reg_to_write_out,
                         data_to_write_out, mwe, rwe, wfa, pcwe, rd, dat);
            end
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] mode; logic [DW-1:0] a, b, expRes; logic [3:0] nz; logic fwe;
        for (int n = 0; n < 8; n++) begin
            mode = 3'($urandom_range(0, 6));
            a = pick_operand(); b = pick_operand();
            fwe = 1'($urandom_range(0, 1));
            ref_alu(mode, a, b, expRes, nz);
            if (fwe) expFlags = nz;
            drive(mode, a, b, 24'd0, 0, fwe, 0, 1, 0, 4'd4, 24'd0);
            step();
            $display("b2b %0d: mode=%0d a=%h b=%h -> result=%h", n, mode, a, b, result);
            checks++;
            if (out_valid !== 1'b1 || result !== expRes || flags !== expFlags || reg_we_out !== 1'b1) begin
                errors++;
                $display("FAIL b2b: txn %0d got valid=%b result=%h flags=%b reg_we=%b, want 1/%h/%b/1", n,
                         out_valid, result, flags, reg_we_out, expRes, expFlags);
            end
        end
        clear_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_redirect();
        test_cmp();
        test_mul();
        test_stall_passthrough();
        test_flush();
        test_reset_mid_busy();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
